// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory bus between instruction fetch (IF) and load/store (MEM).
// MEM has fixed priority with a starvation guard for IF; optional IF wait counter under ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              mem_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
`ifdef ARB_PERF_EN
  output logic [CNT_W-1:0]  perf_if_wait,
`endif
  output logic [1:0]        dbg_state
);

  if (MEM_BURST < 1 || CNT_W < 1) begin : g_param_check
    $error("mem_port_arbiter: MEM_BURST and CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_IF_BUSY  = 2'd1,
    S_MEM_BUSY = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  localparam int            BW        = $clog2(MEM_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MEM_BURST);

  state_t            state_q, state_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic              grant_mem, grant_if;

  // MEM loses only when IF is waiting and MEM already took MEM_BURST grants in a row.
  assign grant_mem = mem_req & ~(if_req & (burst_q == BURST_MAX));
  assign grant_if  = if_req & ~grant_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      burst_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_mem) begin
          state_d     = S_MEM_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          if (!if_req) begin
            burst_d = '0;
          end else if (burst_q != BURST_MAX) begin
            burst_d = burst_q + BW'(1);
          end
        end else if (grant_if) begin
          state_d     = S_IF_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
          burst_d     = '0;
        end
      end
      S_IF_BUSY, S_MEM_BUSY: begin
        // Read data is captured on stores as well; the store requester simply ignores it.
        if (bus_ready) begin
          state_d   = S_RESP;
          bus_req_d = 1'b0;
          if (state_q == S_IF_BUSY) begin
            if_rdata_d = bus_rdata;
            if_ack_d   = 1'b1;
          end else begin
            mem_rdata_d = bus_rdata;
            mem_ack_d   = 1'b1;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef ARB_PERF_EN
  logic [CNT_W-1:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (if_req && (state_q != S_IF_BUSY) && !if_ack_q && (perf_q != {CNT_W{1'b1}})) begin
      perf_d = perf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_if_wait = perf_q;
`endif

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign mem_stall = mem_req & ~mem_ack_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with literal expectations. Perf checks compile only with ARB_PERF_EN.
module tb_mem_port_arbiter;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MEM_BURST = 4;
  localparam int CNT_W     = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack, if_stall;
  logic              mem_req = 1'b0;
  logic              mem_we = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack, mem_stall;
  logic              bus_req, bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata = '0;
  logic              bus_ready = 1'b0;
  logic [1:0]        dbg_state;
`ifdef ARB_PERF_EN
  logic [CNT_W-1:0]  perf_if_wait;
`endif

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BURST(MEM_BURST), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready),
`ifdef ARB_PERF_EN
    .perf_if_wait(perf_if_wait),
`endif
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int ready_delay = 0;
  int busy_k = 0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2008_0005;
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(negedge clk) begin
    #3;
    if (bus_req) busy_k++;
    else busy_k = 0;
    bus_ready = (ready_delay == 0) ? 1'b1 : (busy_k > ready_delay);
    bus_rdata = rd_word(bus_addr);
  end

  // ---------------- reference model ----------------
  // m_ph: 0 idle, 1 access in flight, 2 response cycle. m_streak: MEM grants in a row with IF waiting.
  int               m_ph = 0;
  bit               m_mem_owner = 1'b0;
  int               m_streak = 0;
  logic             e_bus_req = 0, e_bus_we = 0, e_if_ack = 0, e_mem_ack = 0;
  logic [31:0]      e_bus_addr = 0, e_bus_wdata = 0, e_if_rdata = 0, e_mem_rdata = 0;
  logic [CNT_W-1:0] e_perf = 0;
  bit               log_en = 1'b0;
  logic [0:0]       model_log[$];
  logic [0:0]       dut_log[$];
  logic [0:0]       exp_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph = 0; m_mem_owner = 0; m_streak = 0;
      e_bus_req = 0; e_bus_we = 0; e_if_ack = 0; e_mem_ack = 0;
      e_bus_addr = 0; e_bus_wdata = 0; e_if_rdata = 0; e_mem_rdata = 0; e_perf = 0;
    end else begin
      if (if_req && !(m_ph == 1 && !m_mem_owner) && !e_if_ack && e_perf != {CNT_W{1'b1}})
        e_perf = e_perf + 1'b1;
      e_if_ack = 0;
      e_mem_ack = 0;
      if (m_ph == 0) begin
        if (mem_req && !(if_req && m_streak == MEM_BURST)) begin
          m_mem_owner = 1; m_ph = 1;
          e_bus_req = 1; e_bus_we = mem_we; e_bus_addr = mem_addr; e_bus_wdata = mem_wdata;
          m_streak = if_req ? ((m_streak < MEM_BURST) ? m_streak + 1 : m_streak) : 0;
          if (log_en) model_log.push_back(1'b1);
        end else if (if_req) begin
          m_mem_owner = 0; m_ph = 1;
          e_bus_req = 1; e_bus_we = 0; e_bus_addr = if_addr; e_bus_wdata = 0;
          m_streak = 0;
          if (log_en) model_log.push_back(1'b0);
        end
      end else if (m_ph == 1) begin
        if (bus_ready) begin
          e_bus_req = 0; m_ph = 2;
          if (m_mem_owner) begin e_mem_rdata = bus_rdata; e_mem_ack = 1; end
          else begin e_if_rdata = bus_rdata; e_if_ack = 1; end
        end
      end else begin
        m_ph = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  logic prev_bus_req = 1'b0;
  always @(negedge clk) begin
    #1;
    check("bus_req", bus_req, e_bus_req);
    check("bus_we", bus_we, e_bus_we);
    check("bus_addr", bus_addr, e_bus_addr);
    check("bus_wdata", bus_wdata, e_bus_wdata);
    check("if_ack", if_ack, e_if_ack);
    check("mem_ack", mem_ack, e_mem_ack);
    check("if_rdata", if_rdata, e_if_rdata);
    check("mem_rdata", mem_rdata, e_mem_rdata);
    check("if_stall", if_stall, if_req & ~e_if_ack);
    check("mem_stall", mem_stall, mem_req & ~e_mem_ack);
    check("dbg_state", dbg_state,
          (m_ph == 0) ? 32'd0 : (m_ph == 2) ? 32'd3 : (m_mem_owner ? 32'd2 : 32'd1));
`ifdef ARB_PERF_EN
    check("perf_if_wait", perf_if_wait, e_perf);
`endif
    if (log_en && bus_req && !prev_bus_req) dut_log.push_back(bus_addr >= 32'h1000 ? 1'b0 : 1'b1);
    prev_bus_req = bus_req;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #3; end
  endtask

  task automatic do_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
    mem_req = 1; mem_we = we; mem_addr = a; mem_wdata = d;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (mem_ack) begin mem_req = 0; return; end
    end
    n_checks++; n_fail++;
    $display("FAIL mem_ack_timeout: got no ack, expected ack within 60 cycles (addr 0x%08h)", a);
    mem_req = 0;
  endtask

  task automatic do_if(input logic [31:0] a);
    if_req = 1; if_addr = a;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (if_ack) begin if_req = 0; return; end
    end
    n_checks++; n_fail++;
    $display("FAIL if_ack_timeout: got no ack, expected ack within 60 cycles (addr 0x%08h)", a);
    if_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    #1 rst = 0;
    tick(3);
    rst = 1;
    tick(1);

    // Single IF read at minimum latency.
    if_addr = 32'h40; if_req = 1;
    #1;
    check("t1_stall_c0", if_stall, 1);
    check("t1_busreq_c0", bus_req, 0);
    tick(1);
    check("t1_busreq_c1", bus_req, 1);
    check("t1_busaddr_c1", bus_addr, 32'h40);
    check("t1_stall_c1", if_stall, 1);
    tick(1);
    check("t1_ack_c2", if_ack, 1);
    check("t1_rdata_c2", if_rdata, 32'h2008_0005);
    check("t1_stall_c2", if_stall, 0);
    if_req = 0;
    tick(1);
    check("t1_ack_c3", if_ack, 0);
    check("t1_idle_c3", dbg_state, 0);

    // Simultaneous requests: MEM store first, IF right after MEM's response.
    mem_req = 1; mem_we = 1; mem_addr = 32'h10; mem_wdata = 32'hDEAD_BEEF;
    if_req = 1; if_addr = 32'h44;
    tick(1);
    check("t2_busreq_c1", bus_req, 1);
    check("t2_buswe_c1", bus_we, 1);
    check("t2_busaddr_c1", bus_addr, 32'h10);
    check("t2_buswdata_c1", bus_wdata, 32'hDEAD_BEEF);
    tick(1);
    check("t2_memack_c2", mem_ack, 1);
    check("t2_memrdata_c2", mem_rdata, 32'hC0DE_0010);
    check("t2_ifstall_c2", if_stall, 1);
    mem_req = 0; mem_we = 0;
    tick(1);
    check("t2_idle_c3", dbg_state, 0);
    tick(1);
    check("t2_ifgrant_c4", bus_addr, 32'h44);
    check("t2_ifwe_c4", bus_we, 0);
    tick(1);
    check("t2_ifack_c5", if_ack, 1);
    check("t2_ifrdata_c5", if_rdata, 32'hC0DE_0044);
    if_req = 0;
    tick(1);

    // Starvation guard: both held, MEM re-requests after each ack.
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    log_en = 1;
    fork
      begin for (int i = 0; i < 5; i++) do_mem(0, 32'h20 + 32'(4 * i), 32'h0); end
      begin for (int i = 0; i < 2; i++) do_if(32'h1000 + 32'(4 * i)); end
    join
    tick(1);
    log_en = 0;
    check("t3_dut_grants", dut_log.size(), exp_q.size());
    check("t3_model_grants", model_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < dut_log.size()) check($sformatf("t3_dut_order[%0d]", i), dut_log[i], exp_q[i]);
      if (i < model_log.size()) check($sformatf("t3_model_order[%0d]", i), model_log[i], exp_q[i]);
    end

    // Delayed bus_ready on a load: four stable BUSY cycles.
    ready_delay = 3;
    mem_req = 1; mem_we = 0; mem_addr = 32'h30;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      check($sformatf("t4_busreq_c%0d", k), bus_req, 1);
      check($sformatf("t4_busaddr_c%0d", k), bus_addr, 32'h30);
      check($sformatf("t4_buswe_c%0d", k), bus_we, 0);
      check($sformatf("t4_stall_c%0d", k), mem_stall, 1);
      check($sformatf("t4_ack_c%0d", k), mem_ack, 0);
    end
    tick(1);
    check("t4_ack_c5", mem_ack, 1);
    check("t4_rdata_c5", mem_rdata, 32'hC0DE_0030);
    check("t4_stall_c5", mem_stall, 0);
    mem_req = 0;
    tick(1);
    check("t4_ack_c6", mem_ack, 0);

    // Request withdrawn while BUSY still completes and acks.
    ready_delay = 2;
    mem_req = 1; mem_we = 1; mem_addr = 32'h50; mem_wdata = 32'h1234;
    tick(1);
    mem_req = 0;
    tick(3);
    check("t4b_ack_after_drop", mem_ack, 1);
    tick(2);

    // Reset during MEM_BUSY abandons the access.
    ready_delay = 3;
    mem_req = 1; mem_we = 1; mem_addr = 32'h60; mem_wdata = 32'hA5A5_A5A5;
    tick(2);
    check("t5_membusy", dbg_state, 2);
    rst = 0; mem_req = 0; mem_we = 0;
    #1;
    check("t5_rst_busreq", bus_req, 0);
    check("t5_rst_buswe", bus_we, 0);
    check("t5_rst_busaddr", bus_addr, 0);
    check("t5_rst_buswdata", bus_wdata, 0);
    check("t5_rst_memrdata", mem_rdata, 0);
    check("t5_rst_ifrdata", if_rdata, 0);
    check("t5_rst_state", dbg_state, 0);
    tick(2);
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t5_no_ack", mem_ack, 0);
    end
    ready_delay = 0;
    do_mem(0, 32'h64, 32'h0);
    check("t5_fresh_rdata", mem_rdata, 32'hC0DE_0064);
    tick(2);

    // IF blocked behind a two-cycle MEM access.
    rst = 0;
    tick(1);
    rst = 1;
    tick(1);
    ready_delay = 1;
    fork
      do_mem(0, 32'h70, 32'h0);
      do_if(32'h80);
    join
    tick(2);
`ifdef ARB_PERF_EN
    check("t6_perf", perf_if_wait, 5);
    check("t6_model_perf", e_perf, 5);
`endif
    ready_delay = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
